reflet_ram8_initiator: RTL and testbench
========================================

Name: reflet_ram8_initiator

Overview:
Initiator for the reflet 8-bit synchronous RAM port (1-cycle read latency, combinationally gated data_out).
Accepts word-wide load/store requests from the CPU/bus side over a valid/ready handshake.
Serialises each request into consecutive byte accesses on the RAM port, pipelining reads against the RAM latency.
Returns one response pulse per request.

Parameters:
wordSize, 16, CPU word width in bits; one of 8/16/32/64.
addrSize, 7, RAM address width; must equal the attached RAM's addrSize.
ramSize, 128, number of implemented RAM bytes; addresses >= ramSize are out of range.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request (high only in IDLE)
req_write  in  1  1 = store, 0 = load
req_addr  in  addrSize  base byte address
req_size  in  2  access is 2^req_size bytes, clamped to wordSize/8
req_wdata  in  wordSize  store data
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  wordSize  load data; unused upper bytes 0; 0 for stores
rsp_err  out  1  valid with rsp_valid: some byte address was >= ramSize
ram_enable  out  1  to RAM enable
ram_addr  out  addrSize  to RAM addr
ram_write_en  out  1  to RAM write_en
ram_data_in  out  8  to RAM data_in
ram_data_out  in  8  from RAM data_out

Behaviour:
- Reset and clock: reset (synchronous, active-low) and clk (rising edge) as already decided.
- While reset=0: state->IDLE; rsp_valid=0, rsp_rdata=0, rsp_err=0, byte index=0.
- While reset=0, ram_enable and ram_write_en are forced 0 combinationally, including mid-transfer. An interrupted store may leave a partial write; no response is issued.
- State IDLE: req_ready=1, all RAM outputs 0. On req_valid at a clock edge:
  - latch write flag, base address, N = min(2^req_size, wordSize/8), wdata;
  - clear the err accumulator;
  - go to WRITE or READ with idx=0.
- Byte address: (base + idx) mod 2^addrSize; wrap-around is silent. If any byte address is >= ramSize, set the err accumulator. The access is still driven; the RAM ignores it and returns 0.
- State WRITE:
  - ram_enable=1, ram_write_en=1, ram_addr=base+idx, ram_data_in=wdata byte idx (little-endian: byte 0 = bits 7:0);
  - idx++ each cycle; after idx=N-1 go to RESP.
  - Store occupies N WRITE cycles.
- State READ:
  - ram_enable=1, ram_write_en=0, ram_addr=base+idx;
  - from the second READ cycle on, capture ram_data_out into rdata byte idx-1;
  - after issuing idx=N-1 go to LAST.
- State LAST:
  - hold ram_enable=1, ram_write_en=0, ram_addr=base+N-1 (the RAM gates data_out with current enable/addr);
  - capture byte N-1; go to RESP.
- State RESP: rsp_valid=1 for exactly one cycle with rsp_rdata/rsp_err; req_ready=0; RAM outputs 0; next IDLE.
- rsp_rdata/rsp_err are registered and hold their value until the next RESP. rsp_rdata is cleared at request acceptance.
- Latency, accept edge -> rsp_valid high:
  - store: N+1 cycles;
  - load: N+2 cycles.
- Throughput: back-to-back requests are accepted on the cycle after RESP.
- Requests presented outside IDLE are not accepted (req_ready=0). The requester must hold them.

Optional Feature:
REFLET_RAM8_INITIATOR_BIG_ENDIAN_EN:
- Defined: byte at base address is the most significant byte of the N-byte access, for both store data and load data. Data is right-aligned in rsp_rdata/req_wdata.
- Undefined: little-endian as above.
- Timing is unchanged either way.

Decomposition:
- Shared package reflet_mem_pkg: state encoding (IDLE, WRITE, READ, LAST, RESP) and size-clamp helper constant MAX_BYTES = wordSize/8.
- No sub-module needed; optional sub-module reflet_byte_lane for byte select/insert with endianness.

Test Plan:
1. Store 16-bit 0xBEEF at addr 0x10, size 1 -> RAM writes 0xEF@0x10, 0xBE@0x11 on consecutive cycles; rsp_valid 3 cycles after accept; rsp_err=0.
2. Load size 1 from 0x10 after (1) -> rsp_rdata=0xBEEF 4 cycles after accept; ram_enable stays high through LAST.
3. Load 2 bytes at 0x7F (ramSize 128, addrSize 7) -> addresses 0x7F then 0x00 (wrap); rsp_err=0. With ramSize=100, load at 0x63 -> second byte reads 0, rsp_err=1.
4. Store 1 byte 0x5A at 0x20 with req_size=3 on wordSize=16 -> clamped to 2 bytes; then byte load at 0x20 returns 0x005A.
5. Reset pulled low during the 2nd WRITE cycle -> ram_write_en drops same cycle; no rsp_valid; req_ready=1 after reset releases.
6. With REFLET_RAM8_INITIATOR_BIG_ENDIAN_EN: store 0xBEEF at 0x10 -> 0xBE@0x10, 0xEF@0x11; load returns 0xBEEF.

Source files
------------

// File: rtl/reflet_mem_pkg.sv
// reflet_mem_pkg: shared FSM encoding and byte-sizing helpers for the
// reflet 8-bit RAM initiator.
package reflet_mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_LAST,
    ST_RESP
  } state_e;

  // Widest access in bytes for a given CPU word width (MAX_BYTES).
  function automatic int max_bytes(input int word_size);
    return word_size / 8;
  endfunction

  // Byte count of a request: 2^size, clamped to the CPU word width.
  function automatic logic [3:0] clamp_bytes(input logic [1:0] size,
                                             input logic [3:0] max_b);
    logic [3:0] req_b;
    req_b = 4'd1 << size;
    return (req_b > max_b) ? max_b : req_b;
  endfunction

  // Data lane (byte position inside the right-aligned word) that holds the
  // byte at offset idx from the base address of an n-byte access.
  function automatic logic [2:0] byte_lane(input logic [2:0] idx,
                                           input logic [3:0] n,
                                           input logic       big_endian);
    logic [3:0] lane;
    lane = big_endian ? (n - 4'd1 - {1'b0, idx}) : {1'b0, idx};
    return lane[2:0];
  endfunction

endpackage

// File: rtl/reflet_ram8_initiator.sv
// reflet_ram8_initiator: serialises word-wide load/store requests into byte
// accesses on a reflet 8-bit synchronous RAM port (1-cycle read latency,
// data_out gated by the current enable). Reads are pipelined: address k+1 is
// issued while byte k returns; a final LAST cycle collects the last byte.
// Build option: define REFLET_RAM8_INITIATOR_BIG_ENDIAN_EN to place the byte
// at the base address in the most significant lane (default little-endian).
module reflet_ram8_initiator
  import reflet_mem_pkg::*;
#(
  parameter int wordSize = 16,
  parameter int addrSize = 7,
  parameter int ramSize  = 128
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [addrSize-1:0] req_addr,
  input  logic [1:0]          req_size,
  input  logic [wordSize-1:0] req_wdata,
  output logic                rsp_valid,
  output logic [wordSize-1:0] rsp_rdata,
  output logic                rsp_err,
  output logic                ram_enable,
  output logic [addrSize-1:0] ram_addr,
  output logic                ram_write_en,
  output logic [7:0]          ram_data_in,
  input  logic [7:0]          ram_data_out
);

  localparam int         MAX_BYTES = max_bytes(wordSize);
  localparam logic [3:0] MAX_B     = 4'(MAX_BYTES);

`ifdef REFLET_RAM8_INITIATOR_BIG_ENDIAN_EN
  localparam logic BIG_ENDIAN = 1'b1;
`else
  localparam logic BIG_ENDIAN = 1'b0;
`endif

  state_e              state_q, state_d;
  logic [2:0]          idx_q, idx_d;
  logic [3:0]          n_q, n_d;
  logic [addrSize-1:0] base_q, base_d;
  logic [wordSize-1:0] wdata_q, wdata_d;
  logic [wordSize-1:0] rdata_q, rdata_d;
  logic                err_acc_q, err_acc_d;
  logic                rsp_err_q, rsp_err_d;

  logic [addrSize-1:0] cur_addr;
  logic [addrSize-1:0] last_addr;
  logic                cur_oor;
  logic                idx_last;
  logic [2:0]          wr_lane;
  logic [7:0]          wr_byte;
  logic                cap_en;
  logic [2:0]          cap_lane;
  logic                ram_en_c;
  logic                ram_we_c;
  logic [addrSize-1:0] ram_addr_c;
  logic [7:0]          ram_din_c;

  // Byte address of the current index; wrap-around modulo 2^addrSize is silent.
  assign cur_addr  = base_q + addrSize'(idx_q);
  assign last_addr = base_q + addrSize'(n_q - 4'd1);
  assign cur_oor   = (32'(cur_addr) >= 32'(ramSize));
  assign idx_last  = ({1'b0, idx_q} == (n_q - 4'd1));
  assign wr_lane   = byte_lane(idx_q, n_q, BIG_ENDIAN);

  // Next-state, RAM port drive and read-data assembly.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    state_d    = state_q;
    idx_d      = idx_q;
    n_d        = n_q;
    base_d     = base_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_acc_d  = err_acc_q;
    rsp_err_d  = rsp_err_q;
    req_ready  = 1'b0;
    ram_en_c   = 1'b0;
    ram_we_c   = 1'b0;
    ram_addr_c = '0;
    ram_din_c  = 8'h00;
    cap_en     = 1'b0;
    cap_lane   = 3'd0;
    wr_byte    = 8'h00;

    for (int b = 0; b < MAX_BYTES; b++) begin
      if (wr_lane == 3'(b)) wr_byte = wdata_q[b*8 +: 8];
    end

    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          n_d       = clamp_bytes(req_size, MAX_B);
          base_d    = req_addr;
          wdata_d   = req_wdata;
          rdata_d   = '0;
          err_acc_d = 1'b0;
          idx_d     = 3'd0;
          state_d   = req_write ? ST_WRITE : ST_READ;
        end
      end
      ST_WRITE: begin
        ram_en_c   = 1'b1;
        ram_we_c   = 1'b1;
        ram_addr_c = cur_addr;
        ram_din_c  = wr_byte;
        err_acc_d  = err_acc_q | cur_oor;
        idx_d      = idx_q + 3'd1;
        if (idx_last) begin
          rsp_err_d = err_acc_q | cur_oor;
          state_d   = ST_RESP;
        end
      end
      ST_READ: begin
        ram_en_c   = 1'b1;
        ram_addr_c = cur_addr;
        err_acc_d  = err_acc_q | cur_oor;
        // The byte addressed last cycle is on ram_data_out now.
        cap_en     = (idx_q != 3'd0);
        cap_lane   = byte_lane(idx_q - 3'd1, n_q, BIG_ENDIAN);
        idx_d      = idx_q + 3'd1;
        if (idx_last) state_d = ST_LAST;
      end
      ST_LAST: begin
        // Enable and address stay up: the RAM only presents data while enabled.
        ram_en_c   = 1'b1;
        ram_addr_c = last_addr;
        cap_en     = 1'b1;
        cap_lane   = byte_lane(3'(n_q - 4'd1), n_q, BIG_ENDIAN);
        rsp_err_d  = err_acc_q;
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    for (int b = 0; b < MAX_BYTES; b++) begin
      if (cap_en && (cap_lane == 3'(b))) rdata_d[b*8 +: 8] = ram_data_out;
    end
  end

  // Control and response registers, cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= 3'd0;
      rdata_q   <= '0;
      err_acc_q <= 1'b0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rdata_q   <= rdata_d;
      err_acc_q <= err_acc_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  // Request datapath registers, loaded only at acceptance.
  always_ff @(posedge clk) begin
    // NOTE: no reset here; these are always written at acceptance before any use.
    n_q     <= n_d;
    base_q  <= base_d;
    wdata_q <= wdata_d;
  end

  // Reset low kills RAM strobes and the response immediately, even mid-transfer.
  assign ram_enable   = reset & ram_en_c;
  assign ram_write_en = reset & ram_we_c;
  assign ram_addr     = ram_addr_c;
  assign ram_data_in  = ram_din_c;
  assign rsp_valid    = reset & (state_q == ST_RESP);
  assign rsp_rdata    = rdata_q;
  assign rsp_err      = rsp_err_q;

endmodule

// File: tb/tb_reflet_ram8_initiator.sv
// tb_reflet_ram8_initiator: directed and randomized load/store traffic against
// a behavioural RAM and a byte-array reference model; also checks the RAM bus
// sequence, latency and mid-transfer reset.
module tb_reflet_ram8_initiator;

  localparam int WORD_SIZE = 16;
  localparam int ADDR_SIZE = 7;
  localparam int RAM_SIZE  = 100;
  localparam int MAX_BYTES = WORD_SIZE / 8;
  localparam int ADDR_SPAN = 1 << ADDR_SIZE;

`ifdef REFLET_RAM8_INITIATOR_BIG_ENDIAN_EN
  localparam bit BIG_ENDIAN = 1'b1;
`else
  localparam bit BIG_ENDIAN = 1'b0;
`endif

  logic                 clk;
  logic                 reset;
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_write;
  logic [ADDR_SIZE-1:0] req_addr;
  logic [1:0]           req_size;
  logic [WORD_SIZE-1:0] req_wdata;
  logic                 rsp_valid;
  logic [WORD_SIZE-1:0] rsp_rdata;
  logic                 rsp_err;
  logic                 ram_enable;
  logic [ADDR_SIZE-1:0] ram_addr;
  logic                 ram_write_en;
  logic [7:0]           ram_data_in;
  logic [7:0]           ram_data_out;

  int n_compared   = 0;
  int n_mismatched = 0;

  reflet_ram8_initiator #(
    .wordSize(WORD_SIZE),
    .addrSize(ADDR_SIZE),
    .ramSize (RAM_SIZE)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_size    (req_size),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .ram_enable  (ram_enable),
    .ram_addr    (ram_addr),
    .ram_write_en(ram_write_en),
    .ram_data_in (ram_data_in),
    .ram_data_out(ram_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural reflet RAM: 1-cycle read latency, out-of-range ignored / reads 0.
  logic [7:0] ram_mem [RAM_SIZE];
  logic [7:0] ram_rd_q;

  always @(posedge clk) begin
    if (ram_enable) begin
      if (ram_write_en) begin
        if (int'(ram_addr) < RAM_SIZE) ram_mem[int'(ram_addr)] <= ram_data_in;
      end else begin
        ram_rd_q <= (int'(ram_addr) < RAM_SIZE) ? ram_mem[int'(ram_addr)] : 8'h00;
      end
    end
  end

  assign ram_data_out = ram_enable ? ram_rd_q : 8'h00;

  // Reference memory image.
  logic [7:0] model_mem [ADDR_SPAN];

  // RAM bus monitor.
  typedef struct {
    int addr;
    bit we;
    int data;
  } bus_t;

  bus_t bus_q[$];

  always @(negedge clk) begin
    if (ram_enable) bus_q.push_back('{int'(ram_addr), ram_write_en, int'(ram_data_in)});
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int num_bytes(input int size);
    int n;
    n = 1 << size;
    return (n > MAX_BYTES) ? MAX_BYTES : n;
  endfunction

  function automatic int lane_of(input int i, input int n);
    return BIG_ENDIAN ? (n - 1 - i) : i;
  endfunction

  task automatic do_req(input string name, input bit wr, input int addr, input int size,
                        input logic [WORD_SIZE-1:0] wdata);
    int                   n;
    int                   k;
    int                   a;
    bit                   seen;
    bit                   exp_err;
    logic [WORD_SIZE-1:0] exp_rdata;

    n         = num_bytes(size);
    exp_err   = 1'b0;
    exp_rdata = '0;
    for (int i = 0; i < n; i++) begin
      a = (addr + i) % ADDR_SPAN;
      if (a >= RAM_SIZE) exp_err = 1'b1;
      if (a < RAM_SIZE) begin
        if (wr) model_mem[a] = wdata[8*lane_of(i, n) +: 8];
        else    exp_rdata[8*lane_of(i, n) +: 8] = model_mem[a];
      end
    end

    @(negedge clk);
    bus_q.delete();
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = ADDR_SIZE'(addr);
    req_size  = 2'(size);
    req_wdata = wdata;
    #1;
    check({name, ".ready_idle"}, req_ready, 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;

    k    = 0;
    seen = 1'b0;
    while (k < 20 && !seen) begin
      @(negedge clk);
      k++;
      if (k == 1) check({name, ".ready_busy"}, req_ready, 0);
      if (rsp_valid) seen = 1'b1;
    end
    check({name, ".latency"}, k, wr ? n + 1 : n + 2);
    if (seen) begin
      check({name, ".rdata"}, rsp_rdata, wr ? '0 : exp_rdata);
      check({name, ".err"}, rsp_err, exp_err);
      @(negedge clk);
      check({name, ".pulse"}, rsp_valid, 0);
      check({name, ".ready_after"}, req_ready, 1);
      check({name, ".rdata_hold"}, rsp_rdata, wr ? '0 : exp_rdata);
    end

    check({name, ".bus_len"}, bus_q.size(), wr ? n : n + 1);
    for (int i = 0; i < bus_q.size() && i < (wr ? n : n + 1); i++) begin
      int j;
      j = (i < n) ? i : n - 1;
      check($sformatf("%s.bus%0d_addr", name, i), bus_q[i].addr, (addr + j) % ADDR_SPAN);
      check($sformatf("%s.bus%0d_we", name, i), bus_q[i].we, wr);
      if (wr) check($sformatf("%s.bus%0d_data", name, i), bus_q[i].data,
                    int'(wdata[8*lane_of(i, n) +: 8]));
    end
  endtask

  initial begin
    for (int i = 0; i < RAM_SIZE; i++) ram_mem[i] = 8'h00;
    for (int i = 0; i < ADDR_SPAN; i++) model_mem[i] = 8'h00;
    ram_rd_q  = 8'h00;
    reset     = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_size  = 2'd0;
    req_wdata = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset.ready", req_ready, 1);
    check("reset.rsp_valid", rsp_valid, 0);
    check("reset.rdata", rsp_rdata, 0);
    check("reset.err", rsp_err, 0);
    check("reset.ram_enable", ram_enable, 0);
    reset = 1'b1;

    // Directed cases.
    do_req("store_beef", 1'b1, 'h10, 1, 16'hBEEF);
    do_req("load_beef",  1'b0, 'h10, 1, 16'h0000);
    do_req("load_wrap",  1'b0, 'h7F, 1, 16'h0000);
    do_req("load_edge",  1'b0, 'h63, 1, 16'h0000);
    do_req("store_clmp", 1'b1, 'h20, 3, 16'h005A);
    do_req("load_byte",  1'b0, 'h20, 0, 16'h0000);

    // Reset during the second WRITE cycle of a 2-byte store.
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 7'h30;
    req_size  = 2'd1;
    req_wdata = 16'h1234;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("rst_mid.we_first", ram_write_en, 1);
    @(negedge clk);
    check("rst_mid.we_second", ram_write_en, 1);
    reset = 1'b0;
    #1;
    check("rst_mid.we_forced", ram_write_en, 0);
    check("rst_mid.en_forced", ram_enable, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_mid.ready", req_ready, 1);
    check("rst_mid.rdata", rsp_rdata, 0);
    check("rst_mid.err", rsp_err, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_mid.no_rsp", rsp_valid, 0);
    end
    model_mem['h30] = BIG_ENDIAN ? 8'h12 : 8'h34;
    do_req("rst_readback", 1'b0, 'h30, 1, 16'h0000);

    // Randomized traffic.
    for (int t = 0; t < 60; t++) begin
      do_req($sformatf("rnd%0d", t), 1'($urandom_range(0, 1)), int'($urandom_range(0, ADDR_SPAN - 1)),
             int'($urandom_range(0, 3)), WORD_SIZE'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
